// File: rtl/teclado_atm.sv
// Keypad front-end for the ATM controller: debounces raw keys, forwards PIN digits and
// accumulates decimal amounts. Define TECLADO_ECO_EN to add the ECO beeper pulse output.
module teclado_atm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITOS     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TECLA_PRESIONADA,
  input  logic [3:0]  TECLA,
  input  logic        MODO_MONTO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        ERROR_ENTRADA
`ifdef TECLADO_ECO_EN
  ,
  output logic        ECO
`endif
);

  // state        | meaning
  // S_IDLE       | no key down, waiting for a press sample
  // S_CONF_PRESS | counting consecutive press samples with the same code
  // S_HELD       | key accepted, waiting for release (no auto-repeat)
  // S_CONF_REL   | counting consecutive release samples
  typedef enum logic [1:0] {
    S_IDLE,
    S_CONF_PRESS,
    S_HELD,
    S_CONF_REL
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW = $clog2(MAX_DIGITOS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NW-1:0] NDIG_MAX = NW'(MAX_DIGITOS);
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_BORRAR = 4'hB;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      code, code_n;
  logic            fire;

  logic            ev_valid;
  logic [3:0]      ev_code;
  logic            mode_q;

  logic [31:0]     acc, acc_n;
  logic [NW-1:0]   ndig, ndig_n;
  logic [3:0]      digito_n;
  logic [31:0]     monto_n;
  logic            dstb_n, mstb_n, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      code     <= '0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      code     <= code_n;
      ev_valid <= fire;
      ev_code  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code;
    fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (TECLA_PRESIONADA) begin
          code_n = TECLA;
          cnt_n  = CW'(1);
          if (DEBOUNCE_CYCLES == 1) begin
            fire    = 1'b1;
            state_n = S_HELD;
          end else begin
            state_n = S_CONF_PRESS;
          end
        end
      end
      S_CONF_PRESS: begin
        if (!TECLA_PRESIONADA) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (TECLA != code) begin
          // code changed mid-bounce: restart confirmation on the new key
          code_n = TECLA;
          cnt_n  = CW'(1);
        end else if (cnt == CNT_LAST) begin
          cnt_n   = cnt + CW'(1);
          fire    = 1'b1;
          state_n = S_HELD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (!TECLA_PRESIONADA) begin
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE_CYCLES == 1) ? S_IDLE : S_CONF_REL;
        end
      end
      S_CONF_REL: begin
        if (TECLA_PRESIONADA) begin
          state_n = S_HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Mode edge clears the accumulator first; a coincident event then runs in the new mode.
  always_comb begin
    acc_n    = (MODO_MONTO != mode_q) ? 32'd0 : acc;
    ndig_n   = (MODO_MONTO != mode_q) ? '0 : ndig;
    digito_n = DIGITO;
    monto_n  = MONTO;
    dstb_n   = 1'b0;
    mstb_n   = 1'b0;
    err_n    = 1'b0;
    if (ev_valid) begin
      if (!MODO_MONTO) begin
        if (ev_code <= 4'd9) begin
          digito_n = ev_code;
          dstb_n   = 1'b1;
        end
      end else if (ev_code <= 4'd9) begin
        if (ndig_n < NDIG_MAX) begin
          acc_n  = acc_n * 32'd10 + {28'd0, ev_code};
          ndig_n = ndig_n + NW'(1);
        end else begin
          err_n = 1'b1;
        end
      end else if (ev_code == KEY_ENTER) begin
        if (ndig_n != '0) begin
          monto_n = acc_n;
          mstb_n  = 1'b1;
        end else begin
          err_n = 1'b1;
        end
        acc_n  = 32'd0;
        ndig_n = '0;
      end else if (ev_code == KEY_BORRAR) begin
        acc_n  = 32'd0;
        ndig_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= 1'b0;
      acc           <= '0;
      ndig          <= '0;
      DIGITO        <= '0;
      DIGITO_STB    <= 1'b0;
      MONTO         <= '0;
      MONTO_STB     <= 1'b0;
      ERROR_ENTRADA <= 1'b0;
    end else begin
      mode_q        <= MODO_MONTO;
      acc           <= acc_n;
      ndig          <= ndig_n;
      DIGITO        <= digito_n;
      DIGITO_STB    <= dstb_n;
      MONTO         <= monto_n;
      MONTO_STB     <= mstb_n;
      ERROR_ENTRADA <= err_n;
    end
  end

`ifdef TECLADO_ECO_EN
  // Beep on every digit/ENTER/BORRAR event, including rejected ones and in PIN mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ECO <= 1'b0;
    end else begin
      ECO <= ev_valid && (ev_code <= KEY_BORRAR);
    end
  end
`endif

endmodule

// File: tb/tb_teclado_atm.sv
// Self-checking bench for teclado_atm: directed scenarios plus random keying,
// compared every cycle against a run-length reference model of the keypad.
module tb_teclado_atm;
  localparam int D    = 4;
  localparam int MAXD = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        TECLA_PRESIONADA;
  logic [3:0]  TECLA;
  logic        MODO_MONTO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        ERROR_ENTRADA;
`ifdef TECLADO_ECO_EN
  logic        ECO;
`endif

  always #5 clk = ~clk;

  teclado_atm #(.DEBOUNCE_CYCLES(D), .MAX_DIGITOS(MAXD)) dut (
    .clk(clk),
    .rst(rst),
    .TECLA_PRESIONADA(TECLA_PRESIONADA),
    .TECLA(TECLA),
    .MODO_MONTO(MODO_MONTO),
    .DIGITO(DIGITO),
    .DIGITO_STB(DIGITO_STB),
    .MONTO(MONTO),
    .MONTO_STB(MONTO_STB),
    .ERROR_ENTRADA(ERROR_ENTRADA)
`ifdef TECLADO_ECO_EN
    ,
    .ECO(ECO)
`endif
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int press_start = 0;
  int dig_log[$];
  int lat_log[$];
  int monto_log[$];
  int err_cnt = 0;
  int eco_cnt = 0;

  // reference model state
  bit          m_held;
  logic [3:0]  m_code;
  int          m_streak;
  bit          m_pv;
  logic [3:0]  m_pc;
  bit          m_mode;
  longint      m_acc;
  int          m_nd;
  logic [3:0]  e_dig;
  logic [31:0] e_monto;
  bit          e_dstb, e_mstb, e_err, e_eco;

  logic [3:0]  rc;
  int          r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_code = 0; m_streak = 0; m_pv = 0; m_pc = 0; m_mode = 0;
    m_acc = 0; m_nd = 0; e_dig = 0; e_monto = 0;
    e_dstb = 0; e_mstb = 0; e_err = 0; e_eco = 0;
  endtask

  // One clock of the keypad: handle last cycle's accepted key, then take a new sample.
  task automatic model_step();
    e_dstb = 0; e_mstb = 0; e_err = 0; e_eco = 0;
    if (MODO_MONTO !== m_mode) begin
      m_acc = 0;
      m_nd  = 0;
    end
    m_mode = MODO_MONTO;
    if (m_pv) begin
      e_eco = (m_pc <= 11);
      if (!m_mode) begin
        if (m_pc <= 9) begin e_dig = m_pc; e_dstb = 1; end
      end else if (m_pc <= 9) begin
        if (m_nd < MAXD) begin m_acc = m_acc * 10 + m_pc; m_nd++; end
        else e_err = 1;
      end else if (m_pc == 10) begin
        if (m_nd > 0) begin e_monto = 32'(m_acc); e_mstb = 1; end
        else e_err = 1;
        m_acc = 0; m_nd = 0;
      end else if (m_pc == 11) begin
        m_acc = 0; m_nd = 0;
      end
    end
    m_pv = 0;
    if (!m_held) begin
      if (TECLA_PRESIONADA) begin
        if (m_streak > 0 && TECLA == m_code) m_streak++;
        else begin m_code = TECLA; m_streak = 1; end
        if (m_streak == D) begin
          m_held = 1; m_streak = 0; m_pv = 1; m_pc = m_code;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (!TECLA_PRESIONADA) begin
        m_streak++;
        if (m_streak == D) begin m_held = 0; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("digito", DIGITO, e_dig);
    chk("digito_stb", DIGITO_STB, e_dstb);
    chk("monto", MONTO, e_monto);
    chk("monto_stb", MONTO_STB, e_mstb);
    chk("error_entrada", ERROR_ENTRADA, e_err);
    chk("strobe_exclusive", 32'(DIGITO_STB) + 32'(MONTO_STB) + 32'(ERROR_ENTRADA) <= 1, 1);
`ifdef TECLADO_ECO_EN
    chk("eco", ECO, e_eco);
    if (ECO === 1'b1) eco_cnt++;
`endif
    if (DIGITO_STB === 1'b1) begin
      dig_log.push_back(int'(DIGITO));
      lat_log.push_back(ncyc - press_start);
    end
    if (MONTO_STB === 1'b1) monto_log.push_back(int'(MONTO));
    if (ERROR_ENTRADA === 1'b1) err_cnt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    ncyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic key(input logic [3:0] c, input int down = 6, input int up = 6);
    TECLA = c;
    TECLA_PRESIONADA = 1'b1;
    press_start = ncyc;
    repeat (down) cyc();
    TECLA_PRESIONADA = 1'b0;
    repeat (up) cyc();
  endtask

  task automatic clr();
    dig_log.delete(); lat_log.delete(); monto_log.delete();
    err_cnt = 0; eco_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    TECLA_PRESIONADA = 1'b0;
    TECLA = 4'd0;
    MODO_MONTO = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_digito", DIGITO, 0);
    chk("reset_monto", MONTO, 0);
    repeat (3) cyc();

    // 1: PIN digits with clean presses
    clr();
    key(4'd1); key(4'd1); key(4'd9); key(4'd4);
    chk("t1_count", dig_log.size(), 4);
    chk("t1_d0", dig_log[0], 1);
    chk("t1_d1", dig_log[1], 1);
    chk("t1_d2", dig_log[2], 9);
    chk("t1_d3", dig_log[3], 4);
    for (int i = 0; i < 4; i++) chk("t1_latency", lat_log[i], 5);

    // 2: bounce on press, release glitch while held
    clr();
    TECLA = 4'd7;
    TECLA_PRESIONADA = 1'b1; cyc();
    TECLA_PRESIONADA = 1'b0; cyc();
    TECLA_PRESIONADA = 1'b1; cyc();
    repeat (4) cyc();
    repeat (3) cyc();
    TECLA_PRESIONADA = 1'b0; repeat (2) cyc();
    TECLA_PRESIONADA = 1'b1; repeat (4) cyc();
    TECLA_PRESIONADA = 1'b0; repeat (6) cyc();
    chk("t2_count", dig_log.size(), 1);
    chk("t2_digit", dig_log[0], 7);

    // 3: amount entry and empty ENTER
    clr();
    MODO_MONTO = 1'b1; repeat (2) cyc();
    key(4'd1); key(4'd5); key(4'd0); key(4'd0); key(4'd0); key(4'hA);
    chk("t3_monto_count", monto_log.size(), 1);
    chk("t3_monto", monto_log[0], 15000);
    chk("t3_no_err", err_cnt, 0);
    key(4'hA);
    chk("t3_empty_enter_err", err_cnt, 1);
    chk("t3_empty_enter_no_monto", monto_log.size(), 1);

    // 4: overflow digit, max amount, BORRAR
    clr();
    repeat (9) key(4'd9);
    chk("t4_nine_no_err", err_cnt, 0);
    key(4'd9);
    chk("t4_overflow_err", err_cnt, 1);
    key(4'hA);
    chk("t4_max_monto", monto_log[0], 999999999);
    key(4'd4); key(4'd5); key(4'hB); key(4'd1); key(4'd0); key(4'hA);
    chk("t4_after_clear", monto_log[1], 10);
    chk("t4_monto_count", monto_log.size(), 2);

    // 5: mode toggle clears accumulator, then reset mid-press
    clr();
    key(4'd4); key(4'd5);
    MODO_MONTO = 1'b0; repeat (3) cyc();
    MODO_MONTO = 1'b1; repeat (3) cyc();
    key(4'hA);
    chk("t5_err_after_toggle", err_cnt, 1);
    chk("t5_no_monto", monto_log.size(), 0);
    clr();
    MODO_MONTO = 1'b0; repeat (3) cyc();
    TECLA = 4'd3; TECLA_PRESIONADA = 1'b1;
    repeat (2) cyc();
    do_reset();
    chk("t5_rst_digito", DIGITO, 0);
    chk("t5_rst_stb", DIGITO_STB, 0);
    chk("t5_rst_no_event", dig_log.size(), 0);
    press_start = ncyc;
    repeat (8) cyc();
    TECLA_PRESIONADA = 1'b0; repeat (6) cyc();
    chk("t5_rekey_count", dig_log.size(), 1);
    chk("t5_rekey_digit", dig_log[0], 3);
    chk("t5_rekey_latency", lat_log[0], 5);

`ifdef TECLADO_ECO_EN
    // 6: beeper echoes digit and ENTER, not unused codes
    clr();
    key(4'd2); key(4'hC); key(4'hA);
    chk("t6_eco_count", eco_cnt, 2);
`endif

    // random keying with bounce, glitches and mode changes
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) MODO_MONTO = ~MODO_MONTO;
      r = int'($urandom_range(0, 15));
      if (r < 10) rc = 4'(r);
      else if (r < 13) rc = 4'hA;
      else if (r < 14) rc = 4'hB;
      else rc = 4'($urandom_range(12, 15));
      repeat ($urandom_range(0, 3)) begin
        TECLA_PRESIONADA = 1'($urandom_range(0, 1));
        TECLA = ($urandom_range(0, 1) == 1) ? rc : 4'($urandom_range(0, 15));
        cyc();
      end
      TECLA = rc;
      TECLA_PRESIONADA = 1'b1;
      repeat ($urandom_range(1, 8)) begin
        if ($urandom_range(0, 15) == 0) MODO_MONTO = ~MODO_MONTO;
        cyc();
      end
      repeat ($urandom_range(1, 9)) begin
        TECLA_PRESIONADA = ($urandom_range(0, 5) == 0);
        cyc();
      end
    end
    TECLA_PRESIONADA = 1'b0;
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
